// File: rtl/pa_iu_div_ctrl.sv
// pa_iu_div_ctrl
// Sequencer for the IU radix-4 shift divider. Holds the operand registers
// the kernel works on, walks the kernel through its prepare/iterate phases,
// then applies sign correction and the RISC-V divide-by-zero result.

module pa_iu_div_ctrl (
   input  logic        cpurst_b,
   input  logic        div_clk,
   input  logic        div_start,
   input  logic [31:0] div_src0,
   input  logic [31:0] div_src1,
   input  logic        div_signed,
   input  logic        div_rem_sel,
   input  logic        div_flush,
   input  logic        div_iter_cmplt,
   input  logic [31:0] div_quotient_reg_updt,
   input  logic [31:0] div_remainder_reg_updt,
   output logic        div_prepare_src0,
   output logic        div_prepare_src1,
   output logic        div_iterating,
   output logic [4:0]  div_ff1_res,
   output logic [31:0] div_divisor_reg,
   output logic [31:0] div_quotient_reg,
   output logic [31:0] div_remainder_reg,
   output logic        div_idle,
   output logic        div_cmplt,
   output logic [31:0] div_result
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PREP0 = 3'd1,
      PREP1 = 3'd2,
      ITER  = 3'd3,
      FIX   = 3'd4,
      DONE  = 3'd5
   } div_state_t;

   div_state_t  div_state;
   logic        src0_neg;
   logic        src1_neg;
   logic        rem_sel_q;
   logic [31:0] src0_abs;
   logic [31:0] src1_abs;
   logic [31:0] quo_fixed;
   logic [31:0] rem_fixed;
   logic [31:0] ff1_src;
   logic [4:0]  ff1_idx;

   // Operand magnitudes; unsigned operations take the raw bits as-is.
   always_comb begin
      src0_abs = (div_signed && div_src0[31]) ? (32'd0 - div_src0) : div_src0;
      src1_abs = (div_signed && div_src1[31]) ? (32'd0 - div_src1) : div_src1;
   end

   // Sign-corrected results; the remainder follows the dividend sign.
   always_comb begin
      quo_fixed = (src0_neg ^ src1_neg) ? (32'd0 - div_quotient_reg) : div_quotient_reg;
      rem_fixed = src0_neg ? (32'd0 - div_remainder_reg) : div_remainder_reg;
   end

   // Leading-one index of whichever operand is being prepared, 0 otherwise.
   always_comb begin
      ff1_src = div_prepare_src0 ? div_remainder_reg : div_divisor_reg;
      ff1_idx = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (ff1_src[i]) begin
            ff1_idx = i[4:0];
         end
      end
      div_ff1_res = (div_prepare_src0 || div_prepare_src1) ? ff1_idx : 5'd0;
   end

   // Control FSM with registered strobes, operand registers and result.
   always_ff @(posedge div_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         div_state         <= IDLE;
         div_idle          <= 1'b1;
         div_cmplt         <= 1'b0;
         div_prepare_src0  <= 1'b0;
         div_prepare_src1  <= 1'b0;
         div_iterating     <= 1'b0;
         div_divisor_reg   <= 32'd0;
         div_quotient_reg  <= 32'd0;
         div_remainder_reg <= 32'd0;
         div_result        <= 32'd0;
         src0_neg          <= 1'b0;
         src1_neg          <= 1'b0;
         rem_sel_q         <= 1'b0;
      end else begin
         div_cmplt        <= 1'b0;
         div_prepare_src0 <= 1'b0;
         div_prepare_src1 <= 1'b0;
         div_iterating    <= 1'b0;
         if (div_flush) begin
            div_state <= IDLE;
            div_idle  <= 1'b1;
         end else begin
            case (div_state)
               IDLE: begin
                  if (div_start) begin
                     src0_neg          <= div_signed & div_src0[31];
                     src1_neg          <= div_signed & div_src1[31];
                     rem_sel_q         <= div_rem_sel;
                     div_remainder_reg <= src0_abs;
                     div_divisor_reg   <= src1_abs;
                     div_quotient_reg  <= 32'd0;
                     div_idle          <= 1'b0;
                     if (div_src1 == 32'd0) begin
                        div_result <= div_rem_sel ? div_src0 : 32'hFFFF_FFFF;
                        div_cmplt  <= 1'b1;
                        div_state  <= DONE;
                     end else begin
                        div_prepare_src0 <= 1'b1;
                        div_state        <= PREP0;
                     end
                  end
               end
               PREP0: begin
                  div_prepare_src1 <= 1'b1;
                  div_state        <= PREP1;
               end
               PREP1: begin
                  div_iterating <= 1'b1;
                  div_state     <= ITER;
               end
               ITER: begin
                  div_quotient_reg  <= div_quotient_reg_updt;
                  div_remainder_reg <= div_remainder_reg_updt;
                  if (div_iter_cmplt) begin
                     div_state <= FIX;
                  end else begin
                     div_iterating <= 1'b1;
                  end
               end
               FIX: begin
                  div_result <= rem_sel_q ? rem_fixed : quo_fixed;
                  div_cmplt  <= 1'b1;
                  div_state  <= DONE;
               end
               DONE: begin
                  div_idle  <= 1'b1;
                  div_state <= IDLE;
               end
               default: begin
                  div_idle  <= 1'b1;
                  div_state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pa_iu_div_ctrl.sv
// tb_pa_iu_div_ctrl
// Drives divide requests, emulates the shift kernel at a behavioural level
// and compares results, timing and strobes against an arithmetic reference.

module tb_pa_iu_div_ctrl;

   logic        cpurst_b;
   logic        div_clk;
   logic        div_start;
   logic [31:0] div_src0;
   logic [31:0] div_src1;
   logic        div_signed;
   logic        div_rem_sel;
   logic        div_flush;
   logic        div_iter_cmplt;
   logic [31:0] div_quotient_reg_updt;
   logic [31:0] div_remainder_reg_updt;
   logic        div_prepare_src0;
   logic        div_prepare_src1;
   logic        div_iterating;
   logic [4:0]  div_ff1_res;
   logic [31:0] div_divisor_reg;
   logic [31:0] div_quotient_reg;
   logic [31:0] div_remainder_reg;
   logic        div_idle;
   logic        div_cmplt;
   logic [31:0] div_result;

   int passed;
   int total;

   logic [31:0] kq;
   logic [31:0] kr;
   int          kleft;

   pa_iu_div_ctrl dut (
      .cpurst_b               (cpurst_b),
      .div_clk                (div_clk),
      .div_start              (div_start),
      .div_src0               (div_src0),
      .div_src1               (div_src1),
      .div_signed             (div_signed),
      .div_rem_sel            (div_rem_sel),
      .div_flush              (div_flush),
      .div_iter_cmplt         (div_iter_cmplt),
      .div_quotient_reg_updt  (div_quotient_reg_updt),
      .div_remainder_reg_updt (div_remainder_reg_updt),
      .div_prepare_src0       (div_prepare_src0),
      .div_prepare_src1       (div_prepare_src1),
      .div_iterating          (div_iterating),
      .div_ff1_res            (div_ff1_res),
      .div_divisor_reg        (div_divisor_reg),
      .div_quotient_reg       (div_quotient_reg),
      .div_remainder_reg      (div_remainder_reg),
      .div_idle               (div_idle),
      .div_cmplt              (div_cmplt),
      .div_result             (div_result)
   );

   initial div_clk = 1'b0;
   always #5 div_clk = ~div_clk;

   function automatic int msb_of(input logic [31:0] v);
      logic [32:0] w;
      w = {1'b0, v} + 33'd1;
      return (v == 32'd0) ? 0 : ($clog2(w) - 1);
   endfunction

   function automatic logic [31:0] mag_of(input logic [31:0] v, input logic sg);
      int sv;
      sv = v;
      if (sg && sv < 0) return 32'(-sv);
      return v;
   endfunction

   function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic sg, input logic rs);
      int sa, sb;
      logic [31:0] q, r;
      sa = a;
      sb = b;
      if (b == 32'd0) return rs ? a : 32'hFFFF_FFFF;
      if (sg) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return rs ? r : q;
   endfunction

   function automatic int ref_cycles(input logic [31:0] a, input logic [31:0] b, input logic sg);
      int m0, m1, cnt;
      if (b == 32'd0) return 1;
      m0 = msb_of(mag_of(a, sg));
      m1 = msb_of(mag_of(b, sg));
      cnt = (m0 > m1) ? (m0 - m1) : 0;
      return 4 + (cnt / 2 + 1);
   endfunction

   // Behavioural shift kernel: exact answer on the final iteration, noise before it.
   always @(negedge div_clk) begin
      div_iter_cmplt = 1'b0;
      if (div_prepare_src1 && div_divisor_reg != 32'd0) begin
         kq = div_remainder_reg / div_divisor_reg;
         kr = div_remainder_reg % div_divisor_reg;
         kleft = ((msb_of(div_remainder_reg) > msb_of(div_divisor_reg)) ?
                  (msb_of(div_remainder_reg) - msb_of(div_divisor_reg)) : 0) / 2 + 1;
      end
      if (div_iterating) begin
         if (kleft <= 1) begin
            div_iter_cmplt         = 1'b1;
            div_quotient_reg_updt  = kq;
            div_remainder_reg_updt = kr;
         end else begin
            div_quotient_reg_updt  = $urandom;
            div_remainder_reg_updt = $urandom;
         end
         kleft = kleft - 1;
      end
   end

   // One request from the idle cycle through completion and return to idle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic rs, input string name);
      int exp_k, seen_k, n_iter;
      logic [2:0] exp_strb;
      logic [31:0] exp_res;
      exp_k   = ref_cycles(a, b, sg);
      exp_res = ref_result(a, b, sg, rs);
      n_iter  = exp_k - 4;
      seen_k  = 0;
      div_src0 = a;  div_src1 = b;  div_signed = sg;  div_rem_sel = rs;  div_start = 1'b1;
      for (int k = 1; k <= 25 && seen_k == 0; k++) begin
         @(negedge div_clk);
         div_start = 1'b0;
         if (b == 32'd0) exp_strb = 3'b000;
         else exp_strb = {(k >= 3 && k <= 2 + n_iter), (k == 2), (k == 1)};
         total++;
         if ({div_iterating, div_prepare_src1, div_prepare_src0} !== exp_strb)
            $display("[TB] FAIL %s strobes k=%0d got %b want %b", name, k,
                     {div_iterating, div_prepare_src1, div_prepare_src0}, exp_strb);
         else passed++;
         if (k == 1 && b != 32'd0) begin
            total++;
            if (div_remainder_reg !== mag_of(a, sg) || div_divisor_reg !== mag_of(b, sg) ||
                div_quotient_reg !== 32'd0)
               $display("[TB] FAIL %s load got %h/%h/%h want %h/%h/0", name, div_remainder_reg,
                        div_divisor_reg, div_quotient_reg, mag_of(a, sg), mag_of(b, sg));
            else passed++;
            total++;
            if (div_ff1_res !== 5'(msb_of(mag_of(a, sg))))
               $display("[TB] FAIL %s ff1_src0 got %0d want %0d", name, div_ff1_res, msb_of(mag_of(a, sg)));
            else passed++;
         end
         if (k == 2 && b != 32'd0) begin
            total++;
            if (div_ff1_res !== 5'(msb_of(mag_of(b, sg))))
               $display("[TB] FAIL %s ff1_src1 got %0d want %0d", name, div_ff1_res, msb_of(mag_of(b, sg)));
            else passed++;
         end
         if (div_cmplt) seen_k = k;
      end
      total++;
      if (seen_k != exp_k)
         $display("[TB] FAIL %s cmplt_cycle got %0d want %0d", name, seen_k, exp_k);
      else passed++;
      total++;
      if (div_result !== exp_res)
         $display("[TB] FAIL %s result got %h want %h", name, div_result, exp_res);
      else passed++;
      @(negedge div_clk);
      total++;
      if (div_cmplt !== 1'b0 || div_idle !== 1'b1 || div_result !== exp_res)
         $display("[TB] FAIL %s after_done cmplt=%b idle=%b res=%h want 0/1/%h", name,
                  div_cmplt, div_idle, div_result, exp_res);
      else passed++;
   endtask

   // Reset values of every output.
   task automatic test_reset();
      cpurst_b = 1'b0;
      #12;
      total++;
      if (div_idle !== 1'b1 || div_cmplt !== 1'b0 || div_prepare_src0 !== 1'b0 ||
          div_prepare_src1 !== 1'b0 || div_iterating !== 1'b0 || div_ff1_res !== 5'd0)
         $display("[TB] FAIL reset_ctrl idle=%b cmplt=%b strb=%b%b%b ff1=%0d want 1/0/000/0", div_idle,
                  div_cmplt, div_prepare_src0, div_prepare_src1, div_iterating, div_ff1_res);
      else passed++;
      total++;
      if ({div_divisor_reg, div_quotient_reg, div_remainder_reg, div_result} !== 128'd0)
         $display("[TB] FAIL reset_regs got %h %h %h %h want 0", div_divisor_reg,
                  div_quotient_reg, div_remainder_reg, div_result);
      else passed++;
      @(negedge div_clk);
      cpurst_b = 1'b1;
      @(negedge div_clk);
   endtask

   // Worked examples with known quotient/remainder and latency.
   task automatic test_directed();
      run_op(32'd100, 32'd7, 1'b0, 1'b0, "u100_7_q");
      run_op(32'd100, 32'd7, 1'b0, 1'b1, "u100_7_r");
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "s-7_2_q");
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, "s-7_2_r");
      run_op(32'd1, 32'd7, 1'b0, 1'b0, "u1_7_q");
      run_op(32'd1, 32'd7, 1'b0, 1'b1, "u1_7_r");
   endtask

   // Divisor of zero returns immediately without touching the kernel.
   task automatic test_div_by_zero();
      run_op(32'd5, 32'd0, 1'b0, 1'b0, "dz5_q");
      run_op(32'd5, 32'd0, 1'b0, 1'b1, "dz5_r");
      run_op(32'hFFFF_FFF0, 32'd0, 1'b1, 1'b1, "dzneg_r");
   endtask

   // Most negative over minus one; also the longest iteration count.
   task automatic test_overflow();
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "ovf_q");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, "ovf_r");
   endtask

   // Flush during the second ITER cycle together with a start that must be dropped.
   task automatic test_flush();
      logic [31:0] prev;
      int got_cmplt;
      prev = div_result;
      got_cmplt = 0;
      div_src0 = 32'd100;  div_src1 = 32'd7;  div_signed = 1'b0;  div_rem_sel = 1'b0;
      div_start = 1'b1;
      @(negedge div_clk);
      div_start = 1'b0;
      repeat (3) @(negedge div_clk);
      total++;
      if (div_iterating !== 1'b1)
         $display("[TB] FAIL flush_setup iterating got %b want 1", div_iterating);
      else passed++;
      div_flush = 1'b1;
      div_start = 1'b1;
      @(negedge div_clk);
      div_flush = 1'b0;
      div_start = 1'b0;
      total++;
      if (div_idle !== 1'b1 || div_iterating !== 1'b0 || div_cmplt !== 1'b0)
         $display("[TB] FAIL flush_idle idle=%b iter=%b cmplt=%b want 1/0/0", div_idle,
                  div_iterating, div_cmplt);
      else passed++;
      total++;
      if (div_result !== prev)
         $display("[TB] FAIL flush_result got %h want %h", div_result, prev);
      else passed++;
      run_op(32'd100, 32'd7, 1'b0, 1'b1, "post_flush");
      div_flush = 1'b1;
      div_start = 1'b1;
      @(negedge div_clk);
      div_flush = 1'b0;
      div_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (div_cmplt || !div_idle || div_prepare_src0) got_cmplt = 1;
         @(negedge div_clk);
      end
      total++;
      if (got_cmplt != 0)
         $display("[TB] FAIL flush_start_drop got activity=%0d want 0", got_cmplt);
      else passed++;
   endtask

   // Asynchronous reset mid-operation discards the pending completion.
   task automatic test_reset_midop();
      int got_cmplt;
      got_cmplt = 0;
      div_src0 = 32'h8000_0000;  div_src1 = 32'd3;  div_signed = 1'b0;  div_rem_sel = 1'b0;
      div_start = 1'b1;
      @(negedge div_clk);
      div_start = 1'b0;
      repeat (3) @(negedge div_clk);
      #2 cpurst_b = 1'b0;
      #1;
      total++;
      if (div_idle !== 1'b1 || div_iterating !== 1'b0 || div_result !== 32'd0 ||
          div_remainder_reg !== 32'd0)
         $display("[TB] FAIL reset_midop idle=%b iter=%b res=%h rem=%h want 1/0/0/0", div_idle,
                  div_iterating, div_result, div_remainder_reg);
      else passed++;
      @(negedge div_clk);
      cpurst_b = 1'b1;
      for (int k = 0; k < 25; k++) begin
         @(negedge div_clk);
         if (div_cmplt) got_cmplt = 1;
      end
      total++;
      if (got_cmplt != 0)
         $display("[TB] FAIL reset_no_cmplt got %0d want 0", got_cmplt);
      else passed++;
   endtask

   // Random back-to-back requests over mixed widths, signs and zero divisors.
   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 4))
            0: a = a >> $urandom_range(0, 31);
            1: b = b >> $urandom_range(0, 31);
            2: b = (i % 3 == 0) ? 32'd0 : (b >> 28);
            default: ;
         endcase
         run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      passed = 0;
      total = 0;
      kleft = 0;
      kq = 32'd0;
      kr = 32'd0;
      div_start = 1'b0;
      div_src0 = 32'd0;
      div_src1 = 32'd0;
      div_signed = 1'b0;
      div_rem_sel = 1'b0;
      div_flush = 1'b0;
      div_iter_cmplt = 1'b0;
      div_quotient_reg_updt = 32'd0;
      div_remainder_reg_updt = 32'd0;
      test_reset();
      test_directed();
      test_div_by_zero();
      test_overflow();
      test_flush();
      test_reset_midop();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
